// File: rtl/rocketcpu_wb_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rocketcpu_wb_decoder_if : CPU-side and peripheral-side Wishbone    |
// | signal bundle for the address decoder.           Rev 1.0           |
// +--------------------------------------------------------------------+
interface rocketcpu_wb_decoder_if #(
    parameter int NUM_SLAVES = 8,
    parameter int AW         = 32,
    parameter int DW         = 32
);
    logic [AW-1:0]            i_wb_adr;
    logic [DW-1:0]            i_wb_dat;
    logic [DW/8-1:0]          i_wb_sel;
    logic                     i_wb_we;
    logic                     i_wb_cyc;
    logic [DW-1:0]            o_wb_rdt;
    logic                     o_wb_ack;
    logic                     o_wb_err;
    logic [AW-1:0]            o_s_adr;
    logic [DW-1:0]            o_s_dat;
    logic [DW/8-1:0]          o_s_sel;
    logic                     o_s_we;
    logic [NUM_SLAVES-1:0]    o_s_cyc;
    logic [NUM_SLAVES*DW-1:0] i_s_rdt;
    logic [NUM_SLAVES-1:0]    i_s_ack;

    // Decoder view: slave of the CPU bus, master of the peripherals.
    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack, o_wb_err,
        output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
        input  i_s_rdt, i_s_ack
    );

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack, o_wb_err,
        input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc,
        output i_s_rdt, i_s_ack
    );
endinterface
`default_nettype wire

// File: rtl/rocketcpu_wb_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rocketcpu_wb_decoder : base/mask Wishbone decoder with registered  |
// | response mux and bus-timeout watchdog.           Rev 1.0           |
// +--------------------------------------------------------------------+
module rocketcpu_wb_decoder #(
    parameter int                         NUM_SLAVES = 8,
    parameter int                         AW         = 32,
    parameter int                         DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0]   SLAVE_BASE = {32'h0700_0000, 32'h0600_0000,
                                                        32'h0500_0000, 32'h0400_0000,
                                                        32'h0300_0000, 32'h0200_0000,
                                                        32'h0100_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*AW-1:0]   SLAVE_MASK = {8{32'hFF00_0000}},
    parameter int                         TIMEOUT    = 255,
    parameter int                         TW         = 8,
    parameter logic [DW-1:0]              ERR_DATA   = 32'hDEAD_BEEF
) (
    input  wire logic                     i_wb_clk,
    input  wire logic                     i_rst_n,
    rocketcpu_wb_decoder_if.slave         bus,
    output logic                          o_err_sticky,
    output logic [AW-1:0]                 o_err_adr
);
    localparam int             C_IW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [TW-1:0]  C_TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [C_IW-1:0]       idx_q, idx_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DW-1:0]         rdt_q, rdt_d;
    logic [NUM_SLAVES-1:0] scyc_q, scyc_d;
    logic                  sticky_q, sticky_d;
    logic [AW-1:0]         erradr_q, erradr_d;
    logic [AW-1:0]         adr_q, adr_d;

    logic                  w_hit;
    logic [C_IW-1:0]       w_idx;
    logic                  w_sel_ack;
    logic                  w_tmo;

    assign bus.o_s_adr  = bus.i_wb_adr;
    assign bus.o_s_dat  = bus.i_wb_dat;
    assign bus.o_s_sel  = bus.i_wb_sel;
    assign bus.o_s_we   = bus.i_wb_we;
    assign bus.o_s_cyc  = scyc_q;
    assign bus.o_wb_ack = ack_q;
    assign bus.o_wb_err = err_q;
    assign bus.o_wb_rdt = rdt_q;
    assign o_err_sticky = sticky_q;
    assign o_err_adr    = erradr_q;

    // Scanning from the top down lets the lowest matching window win.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.i_wb_adr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                w_hit = 1'b1;
                w_idx = C_IW'(i);
            end
        end
    end

    assign w_sel_ack = bus.i_s_ack[idx_q];
    assign w_tmo     = (TIMEOUT != 0) && (cnt_q == C_TMO_LAST);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdt_d    = rdt_q;
        scyc_d   = scyc_q;
        sticky_d = sticky_q;
        erradr_d = erradr_q;
        adr_d    = adr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.i_wb_cyc) begin
                    adr_d = bus.i_wb_adr;
                    if (w_hit) begin
                        idx_d   = w_idx;
                        scyc_d  = NUM_SLAVES'(1) << w_idx;
                        state_d = S_ACTIVE;
                    end else begin
                        ack_d    = 1'b1;
                        err_d    = 1'b1;
                        rdt_d    = ERR_DATA;
                        sticky_d = 1'b1;
                        erradr_d = bus.i_wb_adr;
                        state_d  = S_RESP;
                    end
                end
            end
            S_ACTIVE: begin
                // An abort beats a late ack: the master is no longer listening.
                if (!bus.i_wb_cyc) begin
                    scyc_d  = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (w_sel_ack) begin
                    rdt_d   = bus.i_s_rdt[idx_q*DW +: DW];
                    ack_d   = 1'b1;
                    scyc_d  = '0;
                    state_d = S_RESP;
                end else if (w_tmo) begin
                    rdt_d    = ERR_DATA;
                    ack_d    = 1'b1;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    erradr_d = adr_q;
                    scyc_d   = '0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                scyc_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdt_q    <= '0;
            scyc_q   <= '0;
            sticky_q <= 1'b0;
            erradr_q <= '0;
            adr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdt_q    <= rdt_d;
            scyc_q   <= scyc_d;
            sticky_q <= sticky_d;
            erradr_q <= erradr_d;
            adr_q    <= adr_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rocketcpu_wb_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rocketcpu_wb_decoder : randomized bench with a behavioural      |
// | decoder/slave model.                              Rev 1.0          |
// +--------------------------------------------------------------------+
module tb_rocketcpu_wb_decoder;
    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam logic [NS*AW-1:0] C_BASE = {32'h1000_0000, 32'h0400_0000, 32'h0200_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] C_MASK = {32'hF000_0000, 32'hFC00_0000, 32'hFF00_0000, 32'hFC00_0000};
    localparam logic [DW-1:0]    C_ERRD = 32'hDEAD_BEEF;

    logic [AW-1:0] base_a [NS] = '{32'h0000_0000, 32'h0200_0000, 32'h0400_0000, 32'h1000_0000};
    logic [AW-1:0] mask_a [NS] = '{32'hFC00_0000, 32'hFF00_0000, 32'hFC00_0000, 32'hF000_0000};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          err_sticky;
    logic [AW-1:0] err_adr;

    always #5 clk = ~clk;

    rocketcpu_wb_decoder_if #(.NUM_SLAVES(NS), .AW(AW), .DW(DW)) bus ();

    rocketcpu_wb_decoder #(
        .NUM_SLAVES (NS),
        .AW         (AW),
        .DW         (DW),
        .SLAVE_BASE (C_BASE),
        .SLAVE_MASK (C_MASK),
        .TIMEOUT    (TMO),
        .TW         (8),
        .ERR_DATA   (C_ERRD)
    ) dut (
        .i_wb_clk     (clk),
        .i_rst_n      (rst_n),
        .bus          (bus.slave),
        .o_err_sticky (err_sticky),
        .o_err_adr    (err_adr)
    );

    // Slave models: slave 1 ties ack high, the others ack after waits[k] cycles.
    int            waits [NS];
    logic [DW-1:0] sdata [NS];
    int            wcnt  [NS];
    logic [NS-1:0] s_ack;
    logic [NS*DW-1:0] s_rdt;

    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) wcnt[k] <= bus.o_s_cyc[k] ? wcnt[k] + 1 : 0;
    end

    always_comb begin
        s_ack = '0;
        s_rdt = '0;
        for (int k = 0; k < NS; k++) begin
            s_ack[k]         = (k == 1) ? 1'b1 : (bus.o_s_cyc[k] && (wcnt[k] >= waits[k]));
            s_rdt[k*DW +: DW] = sdata[k];
        end
    end

    assign bus.i_s_ack = s_ack;
    assign bus.i_s_rdt = s_rdt;

    int            n_checks = 0;
    int            n_errors = 0;
    logic          m_sticky = 1'b0;
    logic [AW-1:0] m_erradr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_decode(input logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) if ((a & mask_a[i]) == base_a[i]) return i;
        return -1;
    endfunction

    // Called right after a falling edge; returns right after a falling edge.
    task automatic run_txn(input logic [AW-1:0] adr);
        int            idx, lat_exp, cyc_exp, got_lat, cyc_cnt, bad;
        logic          err_exp, got_err;
        logic [DW-1:0] rdt_exp, got_rdt;
        logic [NS-1:0] oh;
        idx = model_decode(adr);
        oh  = '0;
        if (idx < 0) begin
            err_exp = 1'b1; lat_exp = 1; cyc_exp = 0; rdt_exp = C_ERRD;
        end else begin
            oh[idx] = 1'b1;
            if (waits[idx] < TMO) begin
                err_exp = 1'b0; lat_exp = waits[idx] + 2; cyc_exp = waits[idx] + 1; rdt_exp = sdata[idx];
            end else begin
                err_exp = 1'b1; lat_exp = TMO + 1; cyc_exp = TMO; rdt_exp = C_ERRD;
            end
        end
        if (err_exp) begin
            m_sticky = 1'b1;
            m_erradr = adr;
        end
        bus.i_wb_adr = adr;
        bus.i_wb_dat = $urandom;
        bus.i_wb_sel = 4'($urandom_range(0, 15));
        bus.i_wb_we  = 1'($urandom_range(0, 1));
        bus.i_wb_cyc = 1'b1;
        got_lat = 0; cyc_cnt = 0; bad = 0; got_err = 1'b0; got_rdt = '0;
        for (int n = 1; n <= 40 && got_lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_s_cyc != '0) begin
                cyc_cnt++;
                if (bus.o_s_cyc != oh) bad++;
            end
            if (bus.o_wb_ack) begin
                got_lat = n;
                got_err = bus.o_wb_err;
                got_rdt = bus.o_wb_rdt;
            end
        end
        check("bcast_adr", 64'(bus.o_s_adr), 64'(adr));
        check("bcast_dat", 64'(bus.o_s_dat), 64'(bus.i_wb_dat));
        check("bcast_sel_we", 64'({bus.o_s_sel, bus.o_s_we}), 64'({bus.i_wb_sel, bus.i_wb_we}));
        bus.i_wb_cyc = 1'b0;
        check("ack_latency", 64'(got_lat), 64'(lat_exp));
        check("resp_err", 64'(got_err), 64'(err_exp));
        check("resp_rdt", 64'(got_rdt), 64'(rdt_exp));
        check("s_cyc_cycles", 64'(cyc_cnt), 64'(cyc_exp));
        check("s_cyc_onehot", 64'(bad), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("ack_one_cycle", 64'(bus.o_wb_ack), 64'd0);
        check("err_one_cycle", 64'(bus.o_wb_err), 64'd0);
        check("rdt_hold", 64'(bus.o_wb_rdt), 64'(rdt_exp));
        check("err_sticky", 64'(err_sticky), 64'(m_sticky));
        check("err_adr", 64'(err_adr), 64'(m_erradr));
    endtask

    task automatic abort_test();
        int acks;
        waits[0] = 10;
        bus.i_wb_adr = 32'h0000_0200;
        bus.i_wb_cyc = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abort_scyc_active", 64'(bus.o_s_cyc), 64'b0001);
        @(posedge clk); @(negedge clk);
        bus.i_wb_cyc = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_scyc_clear", 64'(bus.o_s_cyc), 64'd0);
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            if (bus.o_wb_ack || bus.o_wb_err) acks++;
            @(posedge clk); @(negedge clk);
        end
        check("abort_no_resp", 64'(acks), 64'd0);
        check("abort_sticky", 64'(err_sticky), 64'(m_sticky));
    endtask

    task automatic reset_test();
        waits[2] = 255;
        bus.i_wb_adr = 32'h0400_0000;
        bus.i_wb_cyc = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_pre_scyc", 64'(bus.o_s_cyc), 64'b0100);
        check("rst_pre_sticky", 64'(err_sticky), 64'(m_sticky));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_scyc", 64'(bus.o_s_cyc), 64'd0);
        check("rst_async_sticky", 64'(err_sticky), 64'd0);
        check("rst_async_erradr", 64'(err_adr), 64'd0);
        check("rst_async_rdt", 64'(bus.o_wb_rdt), 64'd0);
        bus.i_wb_cyc = 1'b0;
        m_sticky = 1'b0;
        m_erradr = '0;
        @(negedge clk);
        check("rst_no_ack", 64'({bus.o_wb_ack, bus.o_wb_err}), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int region;
        logic [AW-1:0] a;
        for (int k = 0; k < NS; k++) begin
            waits[k] = 0;
            sdata[k] = $urandom;
        end
        bus.i_wb_adr = '0;
        bus.i_wb_dat = '0;
        bus.i_wb_sel = '0;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_cyc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ack_err", 64'({bus.o_wb_ack, bus.o_wb_err}), 64'd0);
        check("reset_rdt", 64'(bus.o_wb_rdt), 64'd0);
        check("reset_scyc", 64'(bus.o_s_cyc), 64'd0);
        check("reset_sticky", 64'(err_sticky), 64'd0);
        check("reset_erradr", 64'(err_adr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        waits[0] = 0; sdata[0] = 32'h1234_5678;
        run_txn(32'h0000_0100);
        waits[0] = 2; sdata[0] = 32'hCAFE_0001;
        run_txn(32'h0200_0000);
        run_txn(32'h7000_0000);
        waits[2] = 255;
        run_txn(32'h0400_0010);
        waits[3] = 1; sdata[3] = 32'h0BAD_F00D;
        run_txn(32'h1000_0040);
        waits[0] = 3;
        run_txn(32'h0000_0008);
        abort_test();
        waits[0] = 1;
        run_txn(32'h0000_0300);
        reset_test();
        waits[3] = 0;
        run_txn(32'h1234_0000);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NS; k++) begin
                waits[k] = $urandom_range(0, 5);
                sdata[k] = $urandom;
            end
            region = $urandom_range(0, 4);
            a = $urandom;
            case (region)
                0:       a = {6'b000000, a[25:0]};
                1:       a = {8'h02, a[23:0]};
                2:       a = {6'b000001, a[25:0]};
                3:       a = {4'h1, a[27:0]};
                default: a = {2'b01, a[29:0]};
            endcase
            run_txn(a);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end
endmodule
`default_nettype wire
